cpu_sequencer: RTL and testbench

Multi-cycle sequencer for the 8-bit CPU datapath.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Shares the single memory port between instruction fetch and data access.
- Takes the 14-bit control word from `control` and drives the per-cycle enables of the PC, IR, register file, ALU and memory port.
- Adds a memory-wait timeout fault and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/cpu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, control-word fields and opcodes for the CPU sequencer
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } state_t;

  // control word {regdst, branch, memread, memwrite, alusrc, regwrite, opcode, funct}
  localparam int REGDST    = 13;
  localparam int BRANCH    = 12;
  localparam int MEMREAD   = 11;
  localparam int MEMWRITE  = 10;
  localparam int ALUSRC    = 9;
  localparam int REGWRITE  = 8;
  localparam int OPC_MSB   = 7;
  localparam int OPC_LSB   = 4;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;

  localparam logic [3:0] OPC_HALT = 4'hF;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags a request that waited too long
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(MEM_TIMEOUT) + 1;

  logic [W-1:0] wait_cnt;

  // wait counter: clear wins over count so a fresh request always starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (en) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

  // the last permitted wait cycle has passed without the memory answering
  assign expire = en && (wait_cnt == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with memory timeout
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [13:0]      ctrl_sig,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_en,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  state_t      state_q;
  state_t      state_d;
  logic [13:0] ctrl_q;
  logic        in_req;
  logic        tmr_clr;
  logic        tmr_en;
  logic        expire;
  logic        retire;
  logic        rd_q;
  logic        wr_q;
  logic        ctrl_unused;

  assign rd_q = ctrl_q[MEMREAD];
  assign wr_q = ctrl_q[MEMWRITE];

  // fields the sequencer latches but only the datapath consumes
  assign ctrl_unused = ^{ctrl_q[REGDST], ctrl_q[ALUSRC], ctrl_q[OPC_MSB:OPC_LSB],
                         ctrl_q[FUNCT_MSB:FUNCT_LSB]};

  // the timer only runs while the memory port is requested; any state change restarts it
  assign in_req  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign tmr_clr = !in_req || (state_d != state_q);
  assign tmr_en  = in_req && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(expire)
  );

  // an instruction retires on the edge that returns the sequencer to FETCH
  assign retire = (state_d == ST_FETCH) &&
                  ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // control word is captured once per instruction at the end of DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else if (state_q == ST_DECODE) begin
      ctrl_q <= ctrl_sig;
    end
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // next-state and per-cycle enables; FETCH enables are qualified by mem_ready
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (expire) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (ctrl_sig[OPC_MSB:OPC_LSB] == OPC_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        if (ctrl_q[BRANCH] && zero) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
        if (rd_q || wr_q) begin
          state_d = ST_MEM;
        end else if (ctrl_q[REGWRITE]) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = wr_q;
        if (mem_ready) begin
          // read+write together behaves as a store: no write-back
          state_d = (rd_q && !wr_q) ? ST_WB : ST_FETCH;
        end else if (expire) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        wb_sel  = rd_q;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 16;

  localparam logic [10:0] O_REQ  = 11'h400;
  localparam logic [10:0] O_WE   = 11'h200;
  localparam logic [10:0] O_ASEL = 11'h100;
  localparam logic [10:0] O_IRW  = 11'h080;
  localparam logic [10:0] O_PCW  = 11'h040;
  localparam logic [10:0] O_PCS  = 11'h020;
  localparam logic [10:0] O_ALU  = 11'h010;
  localparam logic [10:0] O_RFW  = 11'h008;
  localparam logic [10:0] O_WBS  = 11'h004;
  localparam logic [10:0] O_HLT  = 11'h002;
  localparam logic [10:0] O_FLT  = 11'h001;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [13:0]      ctrl_sig = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
  logic             alu_en, rf_we, wb_sel, halted, fault;
  logic [CNT_W-1:0] instr_count;
  logic [10:0]      obs;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  typedef struct {
    logic        rdy;
    logic [13:0] ctl;
    logic        z;
    logic [10:0] exp;
  } cyc_t;

  cyc_t  cq[$];
  string tq[$];

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_en, rf_we, wb_sel,
                halted, fault};

  cpu_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_sig   (ctrl_sig),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_en     (alu_en),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .halted     (halted),
    .fault      (fault),
    .instr_count(instr_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [13:0] r14();
    return 14'($urandom);
  endfunction

  task automatic push(input logic rdy, input logic [13:0] ctl, input logic z,
                      input logic [10:0] exp, input string tag);
    cyc_t c;
    c.rdy = rdy; c.ctl = ctl; c.z = z; c.exp = exp;
    cq.push_back(c);
    tq.push_back(tag);
  endtask

  // asynchronous reset, released after one edge; leaves the DUT in FETCH just after an edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_outputs", 32'(obs), 32'h0);
    check_eq("rst_count", 32'(instr_count), 32'h0);
    exp_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = rb();
    @(negedge clk);
    check_eq("idle_outputs", 32'(obs), 32'h0);
    @(posedge clk); #1;
  endtask

  // builds the expected cycle-by-cycle behaviour of one instruction from the ISA rules, then plays it
  task automatic run_instr(input logic [13:0] w, input logic z, input int fd, input int md);
    logic br, rd, wr, rw;
    logic [10:0] mem_out;
    br = w[12]; rd = w[11]; wr = w[10]; rw = w[8];
    cq.delete(); tq.delete();
    for (int i = 0; i < fd; i++) push(1'b0, r14(), rb(), O_REQ, "fetch_wait");
    push(1'b1, r14(), rb(), O_REQ | O_IRW | O_PCW, "fetch");
    push(rb(), w, rb(), 11'h0, "decode");
    if (w[7:4] == 4'hF) begin
      for (int i = 0; i < 4; i++) push(rb(), r14(), rb(), O_HLT, "halt");
    end else begin
      push(rb(), r14(), z, O_ALU | ((br && z) ? (O_PCW | O_PCS) : 11'h0), "exec");
      if (rd || wr) begin
        mem_out = O_REQ | O_ASEL | (wr ? O_WE : 11'h0);
        for (int i = 0; i < md; i++) push(1'b0, r14(), rb(), mem_out, "mem_wait");
        push(1'b1, r14(), rb(), mem_out, "mem");
        if (rd && !wr) push(rb(), r14(), rb(), O_RFW | O_WBS, "wb_load");
      end else if (rw) begin
        push(rb(), r14(), rb(), O_RFW, "wb_alu");
      end
      exp_count++;
    end
    for (int i = 0; i < cq.size(); i++) begin
      ctrl_sig  = cq[i].ctl;
      zero      = cq[i].z;
      mem_ready = cq[i].rdy;
      @(negedge clk);
      check_eq(tq[i], 32'(obs), 32'(cq[i].exp));
      @(posedge clk); #1;
    end
    check_eq("instr_count", 32'(instr_count), 32'(exp_count % (1 << CNT_W)));
  endtask

  initial begin
    logic [13:0] w;
    #3;
    do_reset();

    // ALU op with write-back, then load with a slow memory
    run_instr(14'h010D, 1'b0, 0, 0);
    run_instr(14'h0900, 1'b0, 0, 3);

    // taken and not-taken branch
    run_instr(14'h1020, 1'b1, 0, 0);
    run_instr(14'h1020, 1'b0, 0, 0);

    // memory answering on the last permitted cycle is accepted
    run_instr(14'h0103, 1'b0, MEM_TIMEOUT - 1, 0);
    run_instr(14'h0400, 1'b0, 0, MEM_TIMEOUT - 1);
    run_instr(14'h0D00, 1'b0, 1, 2);

    // random instruction mix, never a halt
    for (int n = 0; n < 40; n++) begin
      w = r14();
      if (w[7:4] == 4'hF) w[7:4] = 4'($urandom_range(0, 14));
      run_instr(w, rb(), int'($urandom_range(0, MEM_TIMEOUT - 1)),
                int'($urandom_range(0, MEM_TIMEOUT - 1)));
    end

    // reset pulsed while a load waits in MEM, then a clean restart
    mem_ready = 1'b1; ctrl_sig = 14'h0900;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mem_before_rst", 32'(obs), 32'(O_REQ | O_ASEL));
    #2;
    do_reset();
    run_instr(14'h010D, 1'b0, 0, 0);

    // fetch never answered: FAULT after MEM_TIMEOUT request cycles, held until reset
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      check_eq("timeout_wait", 32'(obs), 32'(O_REQ));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("fault_sticky", 32'(obs), 32'(O_FLT));
      @(posedge clk); #1;
    end
    check_eq("fault_count", 32'(instr_count), 32'h0);
    do_reset();

    // store then halt: counter freezes
    run_instr(14'h0400, 1'b0, 0, 0);
    run_instr(14'h00F0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
